// File: rtl/multi_correlation_judge_if.sv
// multi_correlation_judge_if
//   Groups the round-data handshake and the result/score outputs of the
//   multi-contestant judge so producer and consumer connect with one port.
//
//   Parameters: N (guess width), K (channels), ROUNDS (rounds per game).
//   Signals:
//     Start       game start/restart pulse          (master -> slave)
//     In_valid    round data valid                   (master -> slave)
//     In_ready    round can be accepted              (slave  -> master)
//     Guesses     K packed N-bit guesses             (master -> slave)
//     Target_Num  shared N-bit target                (master -> slave)
//     Scores      K packed SW-bit accumulated scores (slave  -> master)
//     Round       rounds accepted this game          (slave  -> master)
//     Busy        game in progress                   (slave  -> master)
//     Done        Result valid                       (slave  -> master)
//     Result      K-bit winner mask                  (slave  -> master)
interface multi_correlation_judge_if #(
    parameter int N      = 32,
    parameter int K      = 4,
    parameter int ROUNDS = 10
);
    localparam int SW = $clog2(N * ROUNDS + 1);

    logic              Start;
    logic              In_valid;
    logic              In_ready;
    logic [K*N-1:0]    Guesses;
    logic [N-1:0]      Target_Num;
    logic [K*SW-1:0]   Scores;
    logic [7:0]        Round;
    logic              Busy;
    logic              Done;
    logic [K-1:0]      Result;

    modport master (
        output Start, In_valid, Guesses, Target_Num,
        input  In_ready, Scores, Round, Busy, Done, Result
    );

    modport slave (
        input  Start, In_valid, Guesses, Target_Num,
        output In_ready, Scores, Round, Busy, Done, Result
    );
endinterface

// File: rtl/multi_correlation_judge.sv
// multi_correlation_judge
//   K-channel guessing judge. Each accepted round adds, per channel, the
//   number of bit positions where the guess agrees with the target. After
//   ROUNDS rounds a one-cycle DECIDE state flags every channel holding the
//   maximum score (ties all flagged, all-zero scores flag everybody).
//
//   Optional feature macro: EARLY_EXIT_EN
//     defined   - an exact match on any channel ends the game at once with
//                 Result = exact-match mask; scores of that round not added.
//     undefined - exact matches just score N; every game runs all rounds.
//
//   Ports:
//     Clock    rising-edge clock
//     Reset_n  asynchronous active-low reset
//     bus      multi_correlation_judge_if.slave (handshake, guesses, results)
module multi_correlation_judge #(
    parameter int N      = 32,
    parameter int K      = 4,
    parameter int ROUNDS = 10
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    multi_correlation_judge_if.slave   bus
);
    localparam int SW = $clog2(N * ROUNDS + 1);
    localparam int AW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, PLAY, DECIDE, FIN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   score_q [K];
    logic [7:0]      round_q;
    logic [K-1:0]    result_q;
    logic            done_q;

    logic [AW-1:0]   agree [K];
    logic [K-1:0]    max_mask;
    logic [SW-1:0]   max_score;
    logic            restart;
    logic            accept;
    logic            early_hit;
    logic            last_round;
    logic [7:0]      round_inc;

    // Number of bit positions where guess and target agree.
    function automatic logic [AW-1:0] agree_count(input logic [N-1:0] g,
                                                  input logic [N-1:0] t);
        logic [N-1:0]  same;
        logic [AW-1:0] cnt;
        same = ~(g ^ t);
        cnt  = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + AW'(same[i]);
        end
        return cnt;
    endfunction

    always_comb begin
        for (int c = 0; c < K; c++) begin
            agree[c] = agree_count(bus.Guesses[c*N +: N], bus.Target_Num);
        end
    end

`ifdef EARLY_EXIT_EN
    logic [K-1:0] exact;

    always_comb begin
        exact = '0;
        for (int c = 0; c < K; c++) begin
            exact[c] = (bus.Guesses[c*N +: N] == bus.Target_Num);
        end
    end

    assign early_hit = |exact;
`else
    assign early_hit = 1'b0;
`endif

    // Maximum score and the mask of every channel holding it.
    always_comb begin
        max_score = '0;
        max_mask  = '0;
        for (int c = 0; c < K; c++) begin
            if (score_q[c] > max_score) begin
                max_score = score_q[c];
            end
        end
        for (int c = 0; c < K; c++) begin
            max_mask[c] = (score_q[c] == max_score);
        end
    end

    // Start is honoured everywhere except the single DECIDE cycle, which
    // always completes; in PLAY it wins over a simultaneous round.
    assign restart    = bus.Start && (state_q != DECIDE);
    assign accept     = bus.In_valid && (state_q == PLAY) && !restart;
    assign round_inc  = round_q + 8'd1;
    assign last_round = (round_inc == 8'(ROUNDS));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (restart) state_d = PLAY;
            end
            PLAY: begin
                if (restart) begin
                    state_d = PLAY;
                end else if (accept) begin
                    if (early_hit)       state_d = FIN;
                    else if (last_round) state_d = DECIDE;
                end
            end
            DECIDE: begin
                state_d = FIN;
            end
            FIN: begin
                if (restart) state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            round_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            for (int c = 0; c < K; c++) begin
                score_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (restart) begin
                round_q  <= '0;
                result_q <= '0;
                done_q   <= 1'b0;
                for (int c = 0; c < K; c++) begin
                    score_q[c] <= '0;
                end
            end else if (accept) begin
                round_q <= round_inc;
`ifdef EARLY_EXIT_EN
                if (early_hit) begin
                    result_q <= exact;
                    done_q   <= 1'b1;
                end else begin
                    for (int c = 0; c < K; c++) begin
                        score_q[c] <= score_q[c] + SW'(agree[c]);
                    end
                end
`else
                for (int c = 0; c < K; c++) begin
                    score_q[c] <= score_q[c] + SW'(agree[c]);
                end
`endif
            end else if (state_q == DECIDE) begin
                result_q <= max_mask;
                done_q   <= 1'b1;
            end
        end
    end

    assign bus.In_ready = (state_q == PLAY);
    assign bus.Busy     = (state_q == PLAY) || (state_q == DECIDE);
    assign bus.Done     = done_q;
    assign bus.Result   = result_q;
    assign bus.Round    = round_q;

    for (genvar c = 0; c < K; c++) begin : g_scores
        assign bus.Scores[c*SW +: SW] = score_q[c];
    end
endmodule

// File: tb/tb_multi_correlation_judge.sv
// tb_multi_correlation_judge
//   Directed bench for multi_correlation_judge with N=8, K=4, ROUNDS=3.
//   Scores are 5 bits per channel; expectations are written as
//   {ch3, ch2, ch1, ch0} concatenations.
module tb_multi_correlation_judge;
    localparam int N  = 8;
    localparam int K  = 4;
    localparam int R  = 3;
    localparam int SW = 5;

    logic Clock = 1'b0;
    logic Reset_n;
    int   checks   = 0;
    int   failures = 0;
    logic [K*SW-1:0] exp_s;

    always #5 Clock = ~Clock;

    multi_correlation_judge_if #(.N(N), .K(K), .ROUNDS(R)) bus ();

    multi_correlation_judge #(.N(N), .K(K), .ROUNDS(R)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic play_round(input logic [7:0] g0, input logic [7:0] g1,
                              input logic [7:0] g2, input logic [7:0] g3,
                              input logic [7:0] t);
        bus.Guesses    = {g3, g2, g1, g0};
        bus.Target_Num = t;
        bus.In_valid   = 1'b1;
        tick();
        bus.In_valid   = 1'b0;
    endtask

    task automatic start_game;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic test_reset;
        bus.Start = 1'b0; bus.In_valid = 1'b0;
        bus.Guesses = '0; bus.Target_Num = '0;
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        #10;
        checks++;
        if ({bus.Result, bus.Done, bus.Busy, bus.In_ready} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {bus.Result, bus.Done, bus.Busy, bus.In_ready});
        end
        checks++;
        if (bus.Scores !== '0 || bus.Round !== 8'd0) begin
            failures++;
            $display("FAIL reset_data scores=%h round=%0d exp=0", bus.Scores, bus.Round);
        end
        @(negedge Clock) Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_start;
        start_game();
        checks++;
        if ({bus.In_ready, bus.Busy, bus.Done} !== 3'b110 || bus.Round !== 8'd0) begin
            failures++;
            $display("FAIL start rdy/busy/done=%b round=%0d exp=110/0", {bus.In_ready, bus.Busy, bus.Done}, bus.Round);
        end
    endtask

    task automatic test_full_game;
        play_round(8'h0F, 8'h01, 8'hFF, 8'h03, 8'h00);
        play_round(8'h0F, 8'h01, 8'hFF, 8'h03, 8'h00);
        exp_s = {5'd12, 5'd0, 5'd14, 5'd8};
        checks++;
        if (bus.Scores !== exp_s || bus.Round !== 8'd2) begin
            failures++;
            $display("FAIL full_r2 scores=%h round=%0d exp=%h/2", bus.Scores, bus.Round, exp_s);
        end
        play_round(8'h0F, 8'h01, 8'hFF, 8'h03, 8'h00);
        exp_s = {5'd18, 5'd0, 5'd21, 5'd12};
        checks++;
        if (bus.Scores !== exp_s || bus.Round !== 8'd3) begin
            failures++;
            $display("FAIL full_r3 scores=%h round=%0d exp=%h/3", bus.Scores, bus.Round, exp_s);
        end
        checks++;
        if ({bus.Done, bus.In_ready, bus.Busy} !== 3'b001) begin
            failures++;
            $display("FAIL full_decide done/rdy/busy=%b exp=001", {bus.Done, bus.In_ready, bus.Busy});
        end
        tick();
        checks++;
        if (bus.Done !== 1'b1 || bus.Result !== 4'b0010 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL full_result done=%b result=%b busy=%b exp=1/0010/0", bus.Done, bus.Result, bus.Busy);
        end
        // Rounds offered in FIN must be ignored and the verdict held.
        play_round(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        checks++;
        if (bus.Done !== 1'b1 || bus.Result !== 4'b0010 || bus.Scores !== exp_s || bus.Round !== 8'd3) begin
            failures++;
            $display("FAIL fin_hold done=%b result=%b scores=%h round=%0d", bus.Done, bus.Result, bus.Scores, bus.Round);
        end
    endtask

    task automatic test_early_exit;
        start_game();
        checks++;
        if (bus.Done !== 1'b0 || bus.Result !== 4'b0000) begin
            failures++;
            $display("FAIL restart_clear done=%b result=%b exp=0/0000", bus.Done, bus.Result);
        end
        play_round(8'h00, 8'hA4, 8'hFF, 8'h0F, 8'hA5);
        exp_s = {5'd4, 5'd4, 5'd7, 5'd4};
        checks++;
        if (bus.Scores !== exp_s) begin
            failures++;
            $display("FAIL exact_r1 scores=%h exp=%h", bus.Scores, exp_s);
        end
        play_round(8'h00, 8'hA5, 8'hFF, 8'hA5, 8'hA5);
`ifdef EARLY_EXIT_EN
        checks++;
        if (bus.Done !== 1'b1 || bus.Result !== 4'b1010 || bus.Round !== 8'd2 || bus.Scores !== exp_s) begin
            failures++;
            $display("FAIL early done=%b result=%b round=%0d scores=%h exp=1/1010/2/%h", bus.Done, bus.Result, bus.Round, bus.Scores, exp_s);
        end
        play_round(8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5);
        checks++;
        if (bus.In_ready !== 1'b0 || bus.Round !== 8'd2 || bus.Scores !== exp_s) begin
            failures++;
            $display("FAIL early_fin rdy=%b round=%0d scores=%h", bus.In_ready, bus.Round, bus.Scores);
        end
`else
        exp_s = {5'd12, 5'd8, 5'd15, 5'd8};
        checks++;
        if (bus.Done !== 1'b0 || bus.Round !== 8'd2 || bus.Scores !== exp_s) begin
            failures++;
            $display("FAIL exact_r2 done=%b round=%0d scores=%h exp=0/2/%h", bus.Done, bus.Round, bus.Scores, exp_s);
        end
        play_round(8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5);
        tick();
        exp_s = {5'd16, 5'd12, 5'd19, 5'd16};
        checks++;
        if (bus.Done !== 1'b1 || bus.Result !== 4'b0010 || bus.Scores !== exp_s) begin
            failures++;
            $display("FAIL exact_end done=%b result=%b scores=%h exp=1/0010/%h", bus.Done, bus.Result, bus.Scores, exp_s);
        end
`endif
    endtask

    task automatic test_tie;
        start_game();
        for (int i = 0; i < R; i++) play_round(8'h07, 8'hFF, 8'h07, 8'h3F, 8'h00);
        tick();
        exp_s = {5'd6, 5'd15, 5'd0, 5'd15};
        checks++;
        if (bus.Result !== 4'b0101 || bus.Scores !== exp_s || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL tie result=%b scores=%h done=%b exp=0101/%h/1", bus.Result, bus.Scores, bus.Done, exp_s);
        end
    endtask

    task automatic test_all_zero;
        start_game();
        for (int i = 0; i < R; i++) play_round(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        tick();
        checks++;
        if (bus.Result !== 4'b1111 || bus.Scores !== '0 || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL all_zero result=%b scores=%h done=%b exp=1111/0/1", bus.Result, bus.Scores, bus.Done);
        end
    endtask

    task automatic test_stall;
        start_game();
        play_round(8'h01, 8'h03, 8'h07, 8'h0F, 8'h00);
        bus.Guesses = 32'h1234_5678;
        for (int i = 0; i < 5; i++) tick();
        exp_s = {5'd4, 5'd5, 5'd6, 5'd7};
        checks++;
        if (bus.Scores !== exp_s || bus.Round !== 8'd1 || {bus.In_ready, bus.Busy} !== 2'b11) begin
            failures++;
            $display("FAIL stall scores=%h round=%0d rdy/busy=%b exp=%h/1/11", bus.Scores, bus.Round, {bus.In_ready, bus.Busy}, exp_s);
        end
        play_round(8'h01, 8'h03, 8'h07, 8'h0F, 8'h00);
        play_round(8'h01, 8'h03, 8'h07, 8'h0F, 8'h00);
        tick();
        exp_s = {5'd12, 5'd15, 5'd18, 5'd21};
        checks++;
        if (bus.Result !== 4'b0001 || bus.Scores !== exp_s || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL stall_end result=%b scores=%h done=%b exp=0001/%h/1", bus.Result, bus.Scores, bus.Done, exp_s);
        end
    endtask

    task automatic test_start_priority;
        start_game();
        play_round(8'h01, 8'h03, 8'h07, 8'h0F, 8'h00);
        bus.Start = 1'b1; bus.In_valid = 1'b1;
        tick();
        bus.Start = 1'b0; bus.In_valid = 1'b0;
        checks++;
        if (bus.Scores !== '0 || bus.Round !== 8'd0 || bus.In_ready !== 1'b1 || bus.Done !== 1'b0) begin
            failures++;
            $display("FAIL start_prio scores=%h round=%0d rdy=%b done=%b exp=0/0/1/0", bus.Scores, bus.Round, bus.In_ready, bus.Done);
        end
    endtask

    task automatic test_reset_midgame;
        play_round(8'h01, 8'h03, 8'h07, 8'h0F, 8'h00);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (bus.Scores !== '0 || bus.Round !== 8'd0 ||
            {bus.Result, bus.Done, bus.Busy, bus.In_ready} !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid scores=%h round=%0d ctrl=%b exp=0", bus.Scores, bus.Round, {bus.Result, bus.Done, bus.Busy, bus.In_ready});
        end
        @(negedge Clock) Reset_n = 1'b1;
        tick();
        start_game();
        for (int i = 0; i < R; i++) play_round(8'h0F, 8'h01, 8'hFF, 8'h03, 8'h00);
        tick();
        exp_s = {5'd18, 5'd0, 5'd21, 5'd12};
        checks++;
        if (bus.Result !== 4'b0010 || bus.Scores !== exp_s || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL reset_replay result=%b scores=%h done=%b exp=0010/%h/1", bus.Result, bus.Scores, bus.Done, exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_full_game();
        test_early_exit();
        test_tie();
        test_all_zero();
        test_stall();
        test_start_priority();
        test_reset_midgame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_correlation_judge.md
# multi_correlation_judge

Parametrised multi-contestant guessing judge. Each round, K contestants submit N-bit guesses against a shared target. The block accumulates a per-channel bitwise-agreement score over up to ROUNDS rounds. It declares the winner set either early, on an exact match, or at game end, by maximum score with ties all flagged. It sits between the guess-generation logic and the scoreboard/display path and replaces the fixed two-player, fixed-ten-round judge.

## Interface
- N, 32, guess/target width in bits (≥1)
- K, 4, number of contestant channels (2..16)
- ROUNDS, 10, rounds per game (1..255)
- SW (localparam), $clog2(N*ROUNDS+1), score width per channel
- Clock  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  single-cycle pulse: clear scores and begin a new game
- In_valid  in  1  round data valid (guesses + target)
- In_ready  out  1  high while a round can be accepted (state PLAY)
- Guesses  in  K*N  packed guesses; channel c at [c*N +: N]
- Target_Num  in  N  target for this round
- Scores  out  K*SW  packed accumulated scores; channel c at [c*SW +: SW]
- Round  out  8  rounds accepted in the current game
- Busy  out  1  game in progress (PLAY or DECIDE)
- Done  out  1  Result valid; held until next Start or reset
- Result  out  K  winner mask; bit c set = channel c wins

## Operation
- States: IDLE, PLAY, DECIDE, FIN. Reset → IDLE.
- IDLE/FIN + Start → PLAY:
  - Scores, Round, Result cleared.
  - Done cleared.
- PLAY + Start → PLAY, same clearing. Start has priority over a simultaneous In_valid; that round is dropped.
- Accept = In_valid & In_ready. No accept leaves state, Scores and Round unchanged (stall).
- On accept, per channel:
  - exact[c] = (guess_c == Target_Num)
  - agree[c] = popcount(~(guess_c ^ Target_Num)), range 0..N
- Early exit: if any exact[c] on accept:
  - Result ← exact mask (several channels may be set).
  - Scores are not updated; Round increments.
  - State → FIN, Done ← 1.
- Otherwise:
  - Scores[c] += agree[c]; Round += 1.
  - If Round becomes ROUNDS → DECIDE, else stay in PLAY.
- DECIDE (one cycle):
  - Result[c] = (Scores[c] == max over all c).
  - All tied maxima set; all-zero scores give an all-ones mask.
  - Then → FIN, Done ← 1.
- FIN: outputs frozen; In_ready low; In_valid ignored.
- Scores never overflow: SW covers N*ROUNDS.

## Timing
- Reset values:
  - Result = 0, Done = 0, Busy = 0, In_ready = 0
  - Scores = 0, Round = 0
- Asynchronous assert; deassertion is synchronised externally. Reset mid-game aborts immediately to IDLE with all reset values.
- Start at edge t: In_ready = 1 and Busy = 1 from t.
- Scores and Round reflect a round accepted at edge t after t (one cycle).
- Early exit: Done and Result visible after the accepting edge.
- Normal end:
  - Final round accepted at edge t.
  - DECIDE during cycle t..t+1.
  - Done and Result visible after edge t+1.
- In_ready is registered state decode. In_ready is low in DECIDE and FIN.
- Busy = PLAY | DECIDE.
- Done and Result change only on Start, reset, or FIN entry.

## Configuration
- EARLY_EXIT_EN defined: exact-match early exit as described.
- EARLY_EXIT_EN undefined:
  - No early exit; an exact match simply scores N.
  - Every game runs all ROUNDS rounds, then DECIDE.

## Test plan
- N=8, K=4, ROUNDS=3, target 8'h00, all three rounds: guesses ch0 8'h0F, ch1 8'h01, ch2 8'hFF, ch3 8'h03 → Scores 12, 21, 0, 18; Result 4'b0010; Done one cycle after the third accept.
- EARLY_EXIT_EN, round 2: ch1 and ch3 equal target 8'hA5 → Result 4'b1010, Done after that edge, Round = 2, Scores hold round-1 values.
- Tie: ch0 and ch2 both score 15 max over 3 rounds → Result 4'b0101.
- In_valid low for 5 cycles mid-game → Scores and Round unchanged; game completes after remaining accepts.
- Start asserted with In_valid in PLAY after round 1 → scores cleared, that round dropped, Round = 0.
- Reset_n low mid-PLAY (asynchronous, between edges) → all outputs zero immediately; Start afterwards plays a clean game.
